// File: rtl/strob_pkg.sv
// strob_pkg: definitions shared by the strob sequencer and the benches next to strobgen.
//   STATE_W      width of the cycle-state code
//   state_e      state codes IDLE=0 K1=1 K2=2 P1=3 P4=4 P5=5 W=6 (7 is illegal)
//   flags_t      decoder flags latched at the end of K1
//   ss_of_state  state -> one-hot strob selector, bit0=ss11 .. bit4=ss15
//   is_mem_state states whose got is supervised by the no-answer timeout
//   next_state   successor of a state given the latched flags and stop
package strob_pkg;

  localparam int STATE_W = 3;
  localparam int SS_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_K1   = 3'd1,
    S_K2   = 3'd2,
    S_P1   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_W    = 3'd6
  } state_e;

  typedef struct packed {
    logic k2;
    logic p1;
    logic p4;
    logic p5;
  } flags_t;

  function automatic logic [SS_W-1:0] ss_of_state(input logic [STATE_W-1:0] s);
    logic [SS_W-1:0] ss;
    case (s)
      S_K1, S_K2: ss = 5'b00010;  // ss12
      S_P1:       ss = 5'b00001;  // ss11
      S_P4:       ss = 5'b00100;  // ss13
      S_P5:       ss = 5'b01000;  // ss14
      S_W:        ss = 5'b10000;  // ss15
      default:    ss = 5'b00000;
    endcase
    return ss;
  endfunction

  function automatic logic is_mem_state(input logic [STATE_W-1:0] s);
    return (s == S_K1) || (s == S_K2) || (s == S_P4);
  endfunction

  // The optional states are visited in the fixed order K2, P1, P4, P5; each
  // state jumps to the first enabled one after itself, otherwise to W.
  function automatic state_e next_state(input state_e s, input flags_t f, input logic halt);
    state_e n;
    n = S_W;
    case (s)
      S_K1: begin
        if (f.k2)      n = S_K2;
        else if (f.p1) n = S_P1;
        else if (f.p4) n = S_P4;
        else if (f.p5) n = S_P5;
      end
      S_K2: begin
        if (f.p1)      n = S_P1;
        else if (f.p4) n = S_P4;
        else if (f.p5) n = S_P5;
      end
      S_P1: begin
        if (f.p4)      n = S_P4;
        else if (f.p5) n = S_P5;
      end
      S_P4: begin
        if (f.p5)      n = S_P5;
      end
      S_P5:    n = S_W;
      S_W:     n = halt ? S_IDLE : S_K1;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/strob_seq_timeout.sv
// strob_seq_timeout: no-answer supervisor for memory states.
//   __clk, __rst  clock, synchronous active-high reset
//   mem_state     current state is K1, K2 or P4
//   ss_on         a state strob is currently asserted (not in a gap)
//   got           end-of-state pulse from strobgen
//   enter         the sequencer changes state this clock
//   clr_alarm     clears the sticky alarm
//   fire          combinational: the wait limit is reached at this clock edge
//   alarm         sticky timeout flag
// The counter counts clocks in which a memory strob is up without an answer.
// fire is raised on the edge where the count would reach TIMEOUT_TICKS, so the
// strob is seen high for exactly TIMEOUT_TICKS clocks before the abort.
module strob_seq_timeout #(
  parameter int TIMEOUT_TICKS = 255,
  parameter int TO_W          = 8
) (
  input  logic __clk,
  input  logic __rst,
  input  logic mem_state,
  input  logic ss_on,
  input  logic got,
  input  logic enter,
  input  logic clr_alarm,
  output logic fire,
  output logic alarm
);

  logic [TO_W-1:0] cnt_q;
  logic            inc;

  // A state change wins over the limit: the new state starts with a fresh count.
  assign inc  = mem_state & ss_on & ~got & ~enter;
  assign fire = inc && (cnt_q == TO_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge __clk) begin
    if (__rst) begin
      cnt_q <= '0;
      alarm <= 1'b0;
    end else begin
      if (enter || got || !mem_state) begin
        cnt_q <= '0;
      end else if (inc) begin
        cnt_q <= cnt_q + TO_W'(1);
      end
      // Setting dominates clearing when both happen in the same clock.
      if (fire) begin
        alarm <= 1'b1;
      end else if (clr_alarm) begin
        alarm <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/strob_seq.sv
// strob_seq: cycle-state sequencer in front of strobgen.
// Walks one instruction through K1 [K2] [P1] [P4] [P5] W and drives exactly one
// of ss11..ss15 per state. Every state change inserts GAP_TICKS clocks with all
// selectors low so strobgen always sees a fresh rising edge.
//   __clk, __rst      clock, synchronous active-high reset
//   start             begin an instruction cycle (IDLE only, blocked by alarm)
//   stop              sampled at the end of W: 1 -> IDLE, 0 -> next K1
//   need_k2..need_p5  decoder flags, latched at the end of K1
//   got               end-of-state pulse from strobgen
//   clr_alarm         clears the sticky alarm
//   ss11..ss15        registered state strob selectors
//   state             current state code (also the FSM debug view)
//   busy              state != IDLE
//   cycle_done        one-clock pulse after leaving W
//   alarm             sticky memory-timeout flag
// Handshake: start is a level request consumed in the clock it is seen in IDLE
// with no alarm; got is strobgen's answer and its falling edge (got registered
// high, got now low) completes the current state. Falling edges seen during a
// gap or in IDLE are discarded; nothing is queued.
module strob_seq
  import strob_pkg::*;
#(
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 255,
  parameter int TO_W          = 8
) (
  input  logic               __clk,
  input  logic               __rst,
  input  logic               start,
  input  logic               stop,
  input  logic               need_k2,
  input  logic               need_p1,
  input  logic               need_p4,
  input  logic               need_p5,
  input  logic               got,
  input  logic               clr_alarm,
  output logic               ss11,
  output logic               ss12,
  output logic               ss13,
  output logic               ss14,
  output logic               ss15,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               cycle_done,
  output logic               alarm
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

  state_e          state_q, state_d, nxt;
  logic [SS_W-1:0] ss_q, ss_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  flags_t          flags_q, flags_d, flags_in, flags_eff;
  logic            done_q, done_d;
  logic            got_q;
  logic            adv, in_gap, active, enter;
  logic            to_fire, alarm_q;

  assign adv    = got_q & ~got;
  assign in_gap = (gap_q != '0);
  assign active = (state_q >= S_K1) && (state_q <= S_W);
  assign enter  = adv & ~in_gap & active;

  // In K1 the flags are being latched on this very advance, so the successor
  // must be chosen from the live decoder inputs rather than the held copy.
  assign flags_in  = {need_k2, need_p1, need_p4, need_p5};
  assign flags_eff = (state_q == S_K1) ? flags_in : flags_q;
  assign nxt       = next_state(state_q, flags_eff, stop);

  strob_seq_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TO_W          (TO_W)
  ) u_timeout (
    .__clk     (__clk),
    .__rst     (__rst),
    .mem_state (is_mem_state(state_q)),
    .ss_on     (|ss_q),
    .got       (got),
    .enter     (enter),
    .clr_alarm (clr_alarm),
    .fire      (to_fire),
    .alarm     (alarm_q)
  );

  always_ff @(posedge __clk) begin
    if (__rst) begin
      state_q <= S_IDLE;
      ss_q    <= '0;
      gap_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_d;
      gap_q   <= gap_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      got_q   <= got;
    end
  end

  always_comb begin
    state_d = state_q;
    ss_d    = ss_q;
    gap_d   = gap_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (to_fire) begin
      // Memory never answered: abandon the instruction without cycle_done.
      state_d = S_IDLE;
      ss_d    = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // No gap needed: all selectors are already low in IDLE.
          if (start && !alarm_q) begin
            state_d = S_K1;
            ss_d    = ss_of_state(S_K1);
          end
        end
        S_K1, S_K2, S_P1, S_P4, S_P5, S_W: begin
          if (in_gap) begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) begin
              ss_d = ss_of_state(state_q);
            end
          end else if (adv) begin
            state_d = nxt;
            ss_d    = '0;
            gap_d   = (nxt == S_IDLE) ? '0 : GAP_LOAD;
            if (state_q == S_K1) begin
              flags_d = flags_in;
            end
            if (state_q == S_W) begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          ss_d    = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  assign ss11       = ss_q[0];
  assign ss12       = ss_q[1];
  assign ss13       = ss_q[2];
  assign ss14       = ss_q[3];
  assign ss15       = ss_q[4];
  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign cycle_done = done_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_strob_seq.sv
// Bench for strob_seq. Two instances run side by side: d=0 with the default
// timing (gap 1, timeout 255) and d=1 with gap 3, timeout 10. The bench plays
// strobgen: it waits for a selector, answers with a got pulse of random length
// after a random delay, and compares the visited states against a queue built
// from the instruction's decoder flags.
module tb_strob_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, start, stop, got, clr_alarm;
  logic [1:0][3:0] need;  // [0]=k2 [1]=p1 [2]=p4 [3]=p5
  logic [1:0][4:0] ss_v;  // [0]=ss11 .. [4]=ss15
  logic [1:0][2:0] state_v;
  logic [1:0]      busy, cycle_done, alarm;
  logic [1:0]      stop_req, race_start;
  logic            mon_en = 1'b0;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    strob_seq #(
      .GAP_TICKS     ((g == 0) ? 1 : 3),
      .TIMEOUT_TICKS ((g == 0) ? 255 : 10),
      .TO_W          (8)
    ) dut (
      .__clk      (clk),
      .__rst      (rst[g]),
      .start      (start[g]),
      .stop       (stop[g]),
      .need_k2    (need[g][0]),
      .need_p1    (need[g][1]),
      .need_p4    (need[g][2]),
      .need_p5    (need[g][3]),
      .got        (got[g]),
      .clr_alarm  (clr_alarm[g]),
      .ss11       (ss_v[g][0]),
      .ss12       (ss_v[g][1]),
      .ss13       (ss_v[g][2]),
      .ss14       (ss_v[g][3]),
      .ss15       (ss_v[g][4]),
      .state      (state_v[g]),
      .busy       (busy[g]),
      .cycle_done (cycle_done[g]),
      .alarm      (alarm[g])
    );
  end

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int to_of(input int d);
    return (d == 0) ? 255 : 10;
  endfunction

  // Selector each state must show: K1,K2->ss12 P1->ss11 P4->ss13 P5->ss14 W->ss15.
  function automatic logic [4:0] exp_ss(input int st);
    logic [4:0] t [7];
    t = '{5'b00000, 5'b00010, 5'b00010, 5'b00001, 5'b00100, 5'b01000, 5'b10000};
    return (st >= 0 && st < 7) ? t[st] : 5'b00000;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one selector high at any time, on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      assert ($onehot0(ss_v[0]) && $onehot0(ss_v[1])) else $error("ss selectors not one-hot");
      check("ss_onehot0_d0", 32'($onehot0(ss_v[0])), 32'd1);
      check("ss_onehot0_d1", 32'($onehot0(ss_v[1])), 32'd1);
    end
  end

  task automatic check_idle(input int d, input string tag);
    check({tag, "_state"}, 32'(state_v[d]), 32'd0);
    check({tag, "_ss"}, 32'(ss_v[d]), 32'd0);
    check({tag, "_busy"}, 32'(busy[d]), 32'd0);
    check({tag, "_done"}, 32'(cycle_done[d]), 32'd0);
  endtask

  // Entered at the first sample of a state (gap clocks possibly pending).
  // Returns at the sample right after the got falling edge.
  task automatic serve_state(input int d, input int st, input int exp_gap);
    int n;
    int h;
    if (st != 6) stop[d] = ($urandom_range(0, 1) == 1);
    n = 0;
    while (ss_v[d] == 5'd0 && n < 64) begin
      n++;
      tick();
    end
    check("gap_len", 32'(n), 32'(exp_gap));
    check("state", 32'(state_v[d]), 32'(st));
    check("ss_sel", 32'(ss_v[d]), 32'(exp_ss(st)));
    check("busy", 32'(busy[d]), 32'd1);
    check("done_low", 32'(cycle_done[d]), 32'd0);
    h = $urandom_range(0, 3);
    repeat (h) tick();
    if (st == 6 && race_start[d]) begin
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      check("start_in_w", 32'(state_v[d]), 32'd6);
    end
    if (st == 6) stop[d] = stop_req[d];
    got[d] = 1'b1;
    h = $urandom_range(1, 3);
    repeat (h) tick();
    got[d] = 1'b0;
    tick();
    if (st == 6) begin
      check("done_pulse", 32'(cycle_done[d]), 32'd1);
      check("after_w", 32'(state_v[d]), stop_req[d] ? 32'd0 : 32'd1);
      if (stop_req[d]) begin
        tick();
        check_idle(d, "w_to_idle");
      end
    end
  endtask

  // One instruction. With do_start the DUT must be idle; otherwise it has just
  // come out of W into K1 and the gap is still running.
  task automatic run_instr(input int d, input logic [3:0] f, input logic s, input logic do_start);
    int st;
    need[d]       = f;
    stop_req[d]   = s;
    race_start[d] = ($urandom_range(0, 1) == 1);
    exp_q.delete();
    exp_q.push_back(32'd1);
    if (f[0]) exp_q.push_back(32'd2);
    if (f[1]) exp_q.push_back(32'd3);
    if (f[2]) exp_q.push_back(32'd4);
    if (f[3]) exp_q.push_back(32'd5);
    exp_q.push_back(32'd6);
    if (do_start) begin
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
    end
    while (exp_q.size() > 0) begin
      st = int'(exp_q.pop_front());
      serve_state(d, st, (st == 1 && do_start) ? 0 : gap_of(d));
      // Flags are latched at the end of K1; scramble them to prove it.
      if (st == 1) need[d] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic timeout_test(input int d, input logic clr_race);
    int n;
    need[d]       = 4'b0001;
    stop_req[d]   = 1'b1;
    race_start[d] = 1'b0;
    start[d]      = 1'b1;
    tick();
    start[d]      = 1'b0;
    serve_state(d, 1, 0);
    n = 0;
    while (ss_v[d] == 5'd0 && n < 64) begin
      n++;
      tick();
    end
    check("to_gap", 32'(n), 32'(gap_of(d)));
    check("to_in_k2", 32'(state_v[d]), 32'd2);
    n = 0;
    while (ss_v[d] != 5'd0 && n < 400) begin
      n++;
      if (clr_race && n == to_of(d)) clr_alarm[d] = 1'b1;
      tick();
    end
    clr_alarm[d] = 1'b0;
    check("to_ticks", 32'(n), 32'(to_of(d)));
    check("to_alarm", 32'(alarm[d]), 32'd1);
    check_idle(d, "to_abort");
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check("start_blocked", 32'(state_v[d]), 32'd0);
    tick();
    check("start_blocked2", 32'(state_v[d]), 32'd0);
    check("alarm_sticky", 32'(alarm[d]), 32'd1);
    clr_alarm[d] = 1'b1;
    tick();
    clr_alarm[d] = 1'b0;
    check("alarm_clr", 32'(alarm[d]), 32'd0);
    run_instr(d, 4'b0000, 1'b1, 1'b1);
  endtask

  task automatic reset_mid_p4();
    int n;
    need[0]  = 4'b0100;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    serve_state(0, 1, 0);
    n = 0;
    while (ss_v[0] == 5'd0 && n < 64) begin
      n++;
      tick();
    end
    repeat (3) tick();
    check("p4_reached", 32'(state_v[0]), 32'd4);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check_idle(0, "rst_p4");
    check("rst_p4_alarm", 32'(alarm[0]), 32'd0);
    tick();
    check_idle(0, "rst_p4_after");
  endtask

  task automatic reset_mid_gap();
    need[1]  = 4'b0000;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    serve_state(1, 1, 0);
    tick();
    check("gap_pre_rst_ss", 32'(ss_v[1]), 32'd0);
    check("gap_pre_rst_state", 32'(state_v[1]), 32'd6);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check_idle(1, "rst_gap");
    check("rst_gap_alarm", 32'(alarm[1]), 32'd0);
    repeat (4) tick();
    check_idle(1, "rst_gap_after");
  endtask

  // A got falling edge that lands inside the gap must not skip W.
  task automatic gap_race();
    need[1]       = 4'b0000;
    stop_req[1]   = 1'b1;
    race_start[1] = 1'b1;
    start[1]      = 1'b1;
    tick();
    start[1]      = 1'b0;
    serve_state(1, 1, 0);
    got[1] = 1'b1;
    tick();
    got[1] = 1'b0;
    tick();
    check("gap_race_low", 32'(ss_v[1]), 32'd0);
    tick();
    check("gap_race_state", 32'(state_v[1]), 32'd6);
    check("gap_race_ss", 32'(ss_v[1]), 32'(exp_ss(6)));
    serve_state(1, 6, 0);
  endtask

  initial begin
    logic prev_stop;
    logic s;
    rst        = 2'b11;
    start      = '0;
    stop       = '0;
    got        = '0;
    clr_alarm  = '0;
    need       = '0;
    stop_req   = '0;
    race_start = '0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check_idle(d, "reset");
      check("reset_alarm", 32'(alarm[d]), 32'd0);
    end
    rst    = 2'b00;
    mon_en = 1'b1;
    tick();

    run_instr(0, 4'b1111, 1'b1, 1'b1);
    run_instr(0, 4'b0000, 1'b0, 1'b1);
    run_instr(0, 4'b0000, 1'b1, 1'b0);
    timeout_test(0, 1'b0);
    reset_mid_p4();
    reset_mid_gap();
    timeout_test(1, 1'b0);
    gap_race();
    timeout_test(1, 1'b1);
    run_instr(1, 4'b1111, 1'b1, 1'b1);

    for (int d = 0; d < 2; d++) begin
      prev_stop = 1'b1;
      repeat (12) begin
        s = ($urandom_range(0, 1) == 1);
        run_instr(d, 4'($urandom_range(0, 15)), s, prev_stop);
        prev_stop = s;
      end
      if (!prev_stop) run_instr(d, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
